// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - core LSU to external data memory initiator (optional LSU_MISALIGN_TRAP_EN)
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    size_q;
    logic [1:0]    off_q;

    logic          misaligned;
    logic          timeout;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [3:0]    be_raw;
    logic [31:0]   wd_raw;

    logic          req_int, we_int, stall_int, err_int;
    logic [31:0]   rd_int;

    // Misalignment detection only exists when the trap is built in
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = (((core_size_i == SZ_H) || (core_size_i == SZ_HU)) && core_addr_i[0])
                   || ((core_size_i == SZ_W) && (core_addr_i[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    // Timeout fires on the last allowed WAIT cycle when the responder is still silent
    always_comb begin
        timeout = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && !mem_ready_i
               && (cnt_q == TO_LAST);
    end

    // Byte enables and lane-replicated store data from the live request
    always_comb begin
        be_raw = 4'b0000;
        wd_raw = core_wd_i;
        case (core_size_i)
            SZ_B, SZ_BU: begin
                be_raw = 4'b0001 << core_addr_i[1:0];
                wd_raw = {4{core_wd_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be_raw = 4'b0011 << {core_addr_i[1], 1'b0};
                wd_raw = {2{core_wd_i[15:0]}};
            end
            SZ_W:    be_raw = 4'b1111;
            default: be_raw = 4'b0000;
        endcase
    end

    // Load lane extraction uses the size/offset captured when the request issued
    always_comb begin
        byte_sel = mem_rd_i[{off_q, 3'b000} +: 8];
        half_sel = mem_rd_i[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   load_val = {24'h0, byte_sel};
            SZ_H:    load_val = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   load_val = {16'h0, half_sel};
            SZ_W:    load_val = mem_rd_i;
            default: load_val = 32'h0;
        endcase
    end

    // Next state and core/memory handshake
    always_comb begin
        state_d   = state_q;
        stall_int = 1'b0;
        err_int   = 1'b0;
        rd_int    = 32'h0;
        req_int   = core_req_i;
        case (state_q)
            S_IDLE: begin
                if (core_req_i) begin
                    if (misaligned) begin
                        req_int = 1'b0;
                        err_int = 1'b1;
                    end else begin
                        state_d   = S_WAIT;
                        stall_int = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!core_req_i) begin
                    state_d = S_IDLE;
                end else if (mem_ready_i) begin
                    state_d = S_IDLE;
                    rd_int  = core_we_i ? 32'h0 : load_val;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_int = 1'b1;
                end else begin
                    stall_int = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        we_int = req_int & core_we_i;
    end

    // Every output is held low while reset is asserted
    always_comb begin
        core_rd_o    = rst_i ? 32'h0 : rd_int;
        core_stall_o = rst_i ? 1'b0  : stall_int;
        core_err_o   = rst_i ? 1'b0  : err_int;
        mem_req_o    = rst_i ? 1'b0  : req_int;
        mem_we_o     = rst_i ? 1'b0  : we_int;
        mem_be_o     = rst_i ? 4'h0  : be_raw;
        mem_addr_o   = rst_i ? 32'h0 : core_addr_i;
        mem_wd_o     = rst_i ? 32'h0 : wd_raw;
    end

    // State register, WAIT cycle counter and captured load shape
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && (state_d == S_WAIT)) begin
                cnt_q  <= '0;
                size_q <= core_size_i;
                off_q  <= core_addr_i[1:0];
            end else if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    always #5 clk_i = ~clk_i;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .core_err_o(core_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    function automatic logic is_mis(input logic [2:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (((size == 3'd1) || (size == 3'd5)) && addr[0]) || ((size == 3'd2) && (addr[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] be_model(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        for (int lane = 0; lane < 4; lane++) begin
            case (size)
                3'd0, 3'd4: be[lane] = (lane == int'(off));
                3'd1, 3'd5: be[lane] = ((lane / 2) == int'(off[1]));
                3'd2:       be[lane] = 1'b1;
                default:    be[lane] = 1'b0;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] wd_model(input logic [2:0] size, input logic [31:0] wd);
        if (size == 3'd0 || size == 3'd4) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (size == 3'd1 || size == 3'd5) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] ext_model(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(off) * 8 +: 8];
        h = w[int'(off[1]) * 16 +: 16];
        case (size)
            3'd0:    return 32'($signed(b));
            3'd4:    return {24'h0, b};
            3'd1:    return 32'($signed(h));
            3'd5:    return {16'h0, h};
            3'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    // ra: WAIT cycles before mem_ready_i rises (-1 = never). Leaves core_req_i high on return.
    task automatic run_txn(input string name, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] memrd, input int ra);
        exp_t e, got;
        logic mis;
        int lat;
        bit done;
        logic [31:0] rd_seen;
        logic err_seen;
        mis   = is_mis(size, addr);
        e.req = !mis;
        e.we  = we & !mis;
        e.be  = be_model(size, addr[1:0]);
        e.wd  = wd_model(size, wd);
        if (mis) begin
            e.rd = 32'h0; e.err = 1'b1; e.lat = 1;
        end else if (ra < 0 || ra >= TO) begin
            e.rd = 32'h0; e.err = 1'b1; e.lat = TO + 1;
        end else begin
            e.rd = we ? 32'h0 : ext_model(size, addr[1:0], memrd);
            e.err = 1'b0; e.lat = ra + 2;
        end
        sbq.push_back(e);

        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = we; core_size_i = size;
        core_addr_i = addr; core_wd_i = wd; mem_rd_i = memrd;
        done = 0; lat = 0; rd_seen = 32'h0; err_seen = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) begin @(posedge clk_i); #1; end
            mem_ready_i = (c >= 1) && (ra >= 0) && ((c - 1) >= ra);
            @(negedge clk_i);
            if (c == 0) begin
                total++;
                if (mem_req_o !== e.req || mem_we_o !== e.we)
                    $display("FAIL %s req/we: got %b/%b want %b/%b", name, mem_req_o, mem_we_o, e.req, e.we);
                else passed++;
                total++;
                if (mem_be_o !== e.be)
                    $display("FAIL %s be: got %h want %h", name, mem_be_o, e.be);
                else passed++;
                total++;
                if (mem_wd_o !== e.wd || mem_addr_o !== addr)
                    $display("FAIL %s wd/addr: got %h/%h want %h/%h", name, mem_wd_o, mem_addr_o, e.wd, addr);
                else passed++;
            end
            if (core_stall_o === 1'b0) begin
                done = 1; lat = c + 1; rd_seen = core_rd_o; err_seen = core_err_o;
                break;
            end
        end
        got = sbq.pop_front();
        total++;
        if (!done) $display("FAIL %s completion: no completion within 64 cycles", name);
        else if (lat != got.lat) $display("FAIL %s latency: got %0d want %0d", name, lat, got.lat);
        else passed++;
        total++;
        if (rd_seen !== got.rd || err_seen !== got.err)
            $display("FAIL %s rd/err: got %h/%b want %h/%b", name, rd_seen, err_seen, got.rd, got.err);
        else passed++;
    endtask

    task automatic idle_cycle();
        @(posedge clk_i); #1;
        core_req_i = 1'b0; core_we_i = 1'b0; mem_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'hFFFF_FFFC; core_wd_i = 32'h1234_5678; mem_rd_i = 32'hFFFF_FFFF;
        mem_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total++;
        if ({core_rd_o, core_stall_o, core_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !== '0)
            $display("FAIL reset_outputs: got req=%b stall=%b be=%h addr=%h want all zero",
                     mem_req_o, core_stall_o, mem_be_o, mem_addr_o);
        else passed++;
        @(posedge clk_i); #1;
        rst_i = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (core_stall_o !== 1'b0 || mem_req_o !== 1'b0 || core_err_o !== 1'b0)
            $display("FAIL reset_idle: got stall=%b req=%b err=%b want 0/0/0", core_stall_o, mem_req_o, core_err_o);
        else passed++;
    endtask

    task automatic test_store();
        run_txn("sw", 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
        idle_cycle();
        run_txn("sb", 1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 0);
        idle_cycle();
        run_txn("sh", 1'b1, 3'd1, 32'h102, 32'h0000_BEEF, 32'h0, 1);
        idle_cycle();
    endtask

    task automatic test_load();
        run_txn("lb", 1'b0, 3'd0, 32'h103, 32'h0, 32'hA500_0000, 0);
        idle_cycle();
        run_txn("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 32'hA500_0000, 0);
        idle_cycle();
        run_txn("lh", 1'b0, 3'd1, 32'h102, 32'h0, 32'h8001_7FFF, 0);
        idle_cycle();
        run_txn("lhu", 1'b0, 3'd5, 32'h102, 32'h0, 32'h8001_7FFF, 0);
        idle_cycle();
        run_txn("lw", 1'b0, 3'd2, 32'h104, 32'h0, 32'h8001_7FFF, 3);
        idle_cycle();
        run_txn("lh_low", 1'b0, 3'd1, 32'h100, 32'h0, 32'h8001_7FFF, 0);
        idle_cycle();
        run_txn("lb_lane1", 1'b0, 3'd0, 32'h101, 32'h0, 32'h0000_7F00, 2);
        idle_cycle();
    endtask

    task automatic test_timeout();
        run_txn("ready_at_last", 1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFE_F00D, TO - 1);
        idle_cycle();
        run_txn("timeout", 1'b0, 3'd2, 32'h204, 32'h0, 32'hCAFE_F00D, -1);
        idle_cycle();
        run_txn("after_timeout", 1'b0, 3'd2, 32'h208, 32'h0, 32'h0BAD_CAFE, 0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_0", 1'b0, 3'd4, 32'h300, 32'h0, 32'h0000_00F0, 0);
        run_txn("b2b_1", 1'b1, 3'd2, 32'h304, 32'h5555_AAAA, 32'h0, 0);
        run_txn("b2b_2", 1'b0, 3'd1, 32'h306, 32'h0, 32'hFEDC_1234, 1);
        idle_cycle();
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h40; mem_rd_i = 32'h1111_2222; mem_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++;
        if (core_stall_o !== 1'b1 || mem_req_o !== 1'b1)
            $display("FAIL mid_wait_stall: got stall=%b req=%b want 1/1", core_stall_o, mem_req_o);
        else passed++;
        rst_i = 1'b1;
        #1;
        total++;
        if ({core_rd_o, core_stall_o, core_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !== '0)
            $display("FAIL mid_wait_reset: got req=%b stall=%b be=%h addr=%h want all zero",
                     mem_req_o, core_stall_o, mem_be_o, mem_addr_o);
        else passed++;
        @(posedge clk_i); #1;
        rst_i = 1'b0; core_req_i = 1'b0;
        run_txn("lw_after_reset", 1'b0, 3'd2, 32'h0, 32'h0, 32'h1234_5678, 0);
        idle_cycle();
    endtask

    task automatic test_misalign();
        run_txn("lw_mis", 1'b0, 3'd2, 32'h102, 32'h0, 32'h8765_4321, 0);
        idle_cycle();
        run_txn("sh_mis", 1'b1, 3'd1, 32'h101, 32'h0000_1234, 32'h0, 0);
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
